// File: rtl/mainfsm.sv
// mainfsm: multicycle ARM main-decoder Moore FSM driving datapath selects and raw write strobes.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       Undef,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;
    logic [3:0] r_state;
    logic       w_unused;
    assign w_unused = ^Funct[4:1];
    assign State = r_state;
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= FETCH;
        else
            case (r_state)
                FETCH:    r_state <= DECODE;
                DECODE:   r_state <= (Op == 2'b01) ? MEMADR :
                                     (Op == 2'b00) ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                     (Op == 2'b10) ? BRANCH : UNKNOWN;
                MEMADR:   r_state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:    r_state <= MEMWB;
                EXECUTER: r_state <= ALUWB;
                EXECUTEI: r_state <= ALUWB;
                default:  r_state <= FETCH;
            endcase
    end
    // reset masks every output so a mid-instruction reset emits no partial strobe
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        Undef     = 1'b0;
        if (!reset)
            case (r_state)
                FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                MEMADR:   ALUSrcB = 2'b01;
                MEMRD:    AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                end
                MEMWR: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                EXECUTER: ALUOp = 1'b1;
                EXECUTEI: begin
                    ALUSrcB = 2'b01;
                    ALUOp   = 1'b1;
                end
                ALUWB:    RegW = 1'b1;
                BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                end
                default:  Undef = 1'b1;
            endcase
    end
endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: directed state-sequence and per-state output checks for mainfsm.
module tb_mainfsm;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Undef;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;
    logic [13:0] w_outs;
    int checks = 0;
    int failures = 0;
    mainfsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp), .Undef(Undef), .State(State)
    );
    always #5 clk = ~clk;
    assign w_outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, Undef};
    function automatic logic [13:0] exp_out(input logic [3:0] s);
        logic ir, adr, npc, rw, mw, br, aop, und;
        logic [1:0] a, b, r;
        {ir, adr, npc, rw, mw, br, aop, und} = 8'b0;
        {a, b, r} = 6'b0;
        case (s)
            4'd0: begin ir = 1; npc = 1; a = 2'b01; b = 2'b10; r = 2'b10; end
            4'd1: begin a = 2'b01; b = 2'b10; r = 2'b10; end
            4'd2: b = 2'b01;
            4'd3: adr = 1;
            4'd4: begin r = 2'b01; rw = 1; end
            4'd5: begin adr = 1; mw = 1; end
            4'd6: aop = 1;
            4'd7: begin b = 2'b01; aop = 1; end
            4'd8: rw = 1;
            4'd9: begin b = 2'b01; r = 2'b10; br = 1; end
            default: und = 1;
        endcase
        return {ir, adr, a, b, r, npc, rw, mw, br, aop, und};
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // entered at a negedge whose cycle holds seq[0]; returns at the negedge after seq[n-1]
    task automatic run(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [23:0] seq, input int n, input bit scr);
        logic [3:0] cur;
        for (int i = 0; i < n; i++) begin
            cur = seq[4*i +: 4];
            if (scr && cur != 4'd1 && cur != 4'd2) begin
                Op = 2'($urandom);
                Funct = 6'($urandom);
            end else begin
                Op = op;
                Funct = fn;
            end
            #1;
            check({tag, "_state"}, 32'(State), 32'(cur));
            check({tag, "_outs"}, 32'(w_outs), 32'(exp_out(cur)));
            @(negedge clk);
        end
    endtask
    initial begin
        reset = 1'b1;
        Op = 2'b00;
        Funct = 6'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run("pre_str", 2'b01, 6'b011000, {12'd0, 4'd2, 4'd1, 4'd0}, 3, 0);
        reset = 1'b1;
        #1;
        check("rst_in_memwr_state", 32'(State), 32'd5);
        check("rst_in_memwr_outs", 32'(w_outs), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("rst_hold_state", 32'(State), 32'd0);
            check("rst_hold_outs", 32'(w_outs), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            run("dp_reg", 2'b00, 6'b001000, {8'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, p[0]);
            run("dp_imm", 2'b00, 6'b101001, {8'd0, 4'd8, 4'd7, 4'd1, 4'd0}, 4, p[0]);
            run("ldr", 2'b01, 6'b011001, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, p[0]);
            run("str", 2'b01, 6'b011000, {8'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 4, p[0]);
            run("branch", 2'b10, 6'b000000, {12'd0, 4'd9, 4'd1, 4'd0}, 3, p[0]);
            run("undef", 2'b11, 6'b111111, {12'd0, 4'd10, 4'd1, 4'd0}, 3, p[0]);
        end
        run("pre_illegal", 2'b00, 6'b001000, {12'd0, 4'd6, 4'd1, 4'd0}, 3, 0);
        force dut.r_state = 4'd13;
        #1;
        check("illegal_state", 32'(State), 32'd13);
        check("illegal_outs", 32'(w_outs), 32'(exp_out(4'd13)));
        release dut.r_state;
        @(negedge clk);
        #1;
        check("illegal_recover_state", 32'(State), 32'd0);
        check("illegal_recover_outs", 32'(w_outs), 32'(exp_out(4'd0)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
